// File: rtl/seq_match_pkg.sv
// Shared state encoding, default sizing and timer-width helper for the
// sequence match controller and its window matcher.
package seq_match_pkg;

    localparam int DEF_WIN      = 9;
    localparam int DEF_CNT_W    = 8;
    localparam int DEF_TMO_BITS = 64;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN,
        DONE
    } state_t;

    // The timeout timer only ever holds 0 .. tmo_bits-1.
    function automatic int tmr_width(input int tmo_bits);
        return (tmo_bits < 2) ? 1 : $clog2(tmo_bits);
    endfunction

endpackage

// File: rtl/seq_window_match.sv
// Serial shift window with a masked pattern compare on the post-shift window.
// Only WIN-1 history bits are stored; the newest bit comes straight from bit_in.
module seq_window_match
    import seq_match_pkg::*;
#(
    parameter int WIN = DEF_WIN
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           shift_en,
    input  logic           clear,
    input  logic           bit_in,
    input  logic [WIN-1:0] pattern,
    input  logic [WIN-1:0] mask,
    output logic           hit
);

    logic [WIN-2:0] hist;
    logic [WIN-1:0] window_nxt;

    assign window_nxt = {hist, bit_in};
    assign hit        = ((window_nxt ^ pattern) & mask) == '0;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hist <= '0;
        end else if (shift_en) begin
            hist <= window_nxt[WIN-2:0];
        end
    end

endmodule

// File: rtl/seq_match_ctrl.sv
// Sequence match controller: config handshake, run FSM, hit counting.
// Optional beat timeout in RUN is compiled in with SEQ_MATCH_TIMEOUT_EN.
module seq_match_ctrl
    import seq_match_pkg::*;
#(
    parameter int WIN      = DEF_WIN,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int TMO_BITS = DEF_TMO_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIN-1:0]   cfg_pattern,
    input  logic [WIN-1:0]   cfg_mask,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             start,
    input  logic             abort,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done,
    output logic             timeout
);

    localparam int FILL_W = $clog2(WIN + 1);

    state_t           state, state_nxt;
    logic [WIN-1:0]   pattern_q, mask_q;
    logic [CNT_W-1:0] target_q, cnt_q, cnt_nxt;
    logic [FILL_W-1:0] fill_q, fill_nxt;
    logic [CNT_W:0]   cnt_inc;
    logic             match_q, match_nxt;
    logic             cfg_xfer, win_shift, win_clear, win_hit;
    logic             fill_full, eval, hit_ok, target_reached;

`ifdef SEQ_MATCH_TIMEOUT_EN
    localparam int TMR_W = tmr_width(TMO_BITS);
    logic [TMR_W-1:0] tmr_q, tmr_nxt;
    logic             tmo_q, tmo_nxt;
`endif

    assign cfg_ready = (state == IDLE);
    assign cfg_xfer  = cfg_valid && cfg_ready;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE) && !abort;
    assign match     = match_q;
    assign match_cnt = cnt_q;

    assign win_shift = bit_valid && ((state == ARM) || (state == RUN));
    assign win_clear = (state == IDLE) && start;
    assign fill_full = (fill_q == FILL_W'(WIN - 1));
    // In ARM only the beat that completes the window is evaluated.
    assign eval      = win_shift && ((state == RUN) || fill_full);
    assign hit_ok    = eval && win_hit && !abort;
    assign cnt_inc   = {1'b0, cnt_q} + 1'b1;
    assign target_reached = (target_q != '0) && (cnt_inc == {1'b0, target_q});

    seq_window_match #(.WIN(WIN)) u_window (
        .clk      (clk),
        .rst      (rst),
        .shift_en (win_shift),
        .clear    (win_clear),
        .bit_in   (bit_in),
        .pattern  (pattern_q),
        .mask     (mask_q),
        .hit      (win_hit)
    );

    always_comb begin
        state_nxt = state;
        fill_nxt  = fill_q;
        cnt_nxt   = cnt_q;
        match_nxt = 1'b0;
`ifdef SEQ_MATCH_TIMEOUT_EN
        tmr_nxt   = tmr_q;
        tmo_nxt   = tmo_q;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ARM;
                    fill_nxt  = '0;
                    cnt_nxt   = '0;
`ifdef SEQ_MATCH_TIMEOUT_EN
                    tmr_nxt   = '0;
                    tmo_nxt   = 1'b0;
`endif
                end
            end
            ARM: begin
                if (bit_valid) begin
                    if (fill_full) state_nxt = RUN;
                    else           fill_nxt  = fill_q + 1'b1;
                end
            end
            RUN: begin
`ifdef SEQ_MATCH_TIMEOUT_EN
                // A hit on the final allowed beat wins over the timeout.
                if (bit_valid) begin
                    if (win_hit) begin
                        tmr_nxt = '0;
                    end else if (tmr_q == TMR_W'(TMO_BITS - 1)) begin
                        state_nxt = DONE;
                        tmo_nxt   = 1'b1;
                    end else begin
                        tmr_nxt = tmr_q + 1'b1;
                    end
                end
`endif
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (hit_ok) begin
            match_nxt = 1'b1;
            if (cnt_q != '1) cnt_nxt = cnt_q + 1'b1;
            if (target_reached) state_nxt = DONE;
        end

        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
`ifdef SEQ_MATCH_TIMEOUT_EN
            tmo_nxt   = tmo_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pattern_q <= '0;
            mask_q    <= '0;
            target_q  <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
            match_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            fill_q  <= fill_nxt;
            cnt_q   <= cnt_nxt;
            match_q <= match_nxt;
            if (cfg_xfer) begin
                pattern_q <= cfg_pattern;
                mask_q    <= cfg_mask;
                target_q  <= cfg_target;
            end
        end
    end

`ifdef SEQ_MATCH_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            tmr_q <= tmr_nxt;
            tmo_q <= tmo_nxt;
        end
    end

    assign timeout = tmo_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Directed bench for seq_match_ctrl: a per-cycle vector table plus
// hand-written multi-cycle sequences (saturation, abort, reset, timeout).
`timescale 1ns/1ps
module tb_seq_match_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [8:0] cfg_pattern;
    logic [8:0] cfg_mask;
    logic [7:0] cfg_target;
    logic       start;
    logic       abort;
    logic       bit_valid;
    logic       bit_in;
    logic       match;
    logic [7:0] match_cnt;
    logic       busy;
    logic       done;
    logic       timeout;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    seq_match_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_mask    (cfg_mask),
        .cfg_target  (cfg_target),
        .start       (start),
        .abort       (abort),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .match       (match),
        .match_cnt   (match_cnt),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout)
    );

    typedef struct {
        logic       cv;
        logic [8:0] pat;
        logic [8:0] msk;
        logic [7:0] tgt;
        logic       st;
        logic       ab;
        logic       bv;
        logic       bi;
        logic       e_match;
        logic       e_done;
        logic       e_busy;
        logic       e_ready;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input logic cv, input logic [8:0] pat, input logic [8:0] msk,
                                    input logic [7:0] tgt, input logic st, input logic ab,
                                    input logic bv, input logic bi, input logic e_match,
                                    input logic e_done, input logic e_busy, input logic e_ready,
                                    input logic [7:0] e_cnt);
        vec_t v;
        v.cv = cv; v.pat = pat; v.msk = msk; v.tgt = tgt;
        v.st = st; v.ab = ab; v.bv = bv; v.bi = bi;
        v.e_match = e_match; v.e_done = e_done; v.e_busy = e_busy;
        v.e_ready = e_ready; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endfunction

    // Drive one cycle of inputs and return #1 after the sampling edge.
    task automatic applyStimulus(input logic cv, input logic [8:0] pat, input logic [8:0] msk,
                                 input logic [7:0] tgt, input logic st, input logic ab,
                                 input logic bv, input logic bi);
        cfg_valid   = cv;
        cfg_pattern = pat;
        cfg_mask    = msk;
        cfg_target  = tgt;
        start       = st;
        abort       = ab;
        bit_valid   = bv;
        bit_in      = bi;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic b);
        applyStimulus(1'b0, 9'h000, 9'h000, 8'h00, 1'b0, 1'b0, 1'b1, b);
    endtask

    task automatic idle_cycle();
        applyStimulus(1'b0, 9'h000, 9'h000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic abort_cycle();
        applyStimulus(1'b0, 9'h000, 9'h000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    localparam logic [8:0]  PAT_A  = 9'b011000110;
    localparam logic [8:0]  MSK_A  = 9'b111000111;
    localparam logic [8:0]  PAT_B  = 9'b101010101;
    localparam logic [17:0] STREAM = 18'b011101110_011010110;
    localparam logic [7:0]  GUARD  = 8'b11000110;

    initial begin
        logic       done_seen;
        logic       match_seen;
        logic       b;
        logic       hit;
        logic [7:0] cnt;

        rst = 1'b1;
        cfg_valid = 1'b0; cfg_pattern = '0; cfg_mask = '0; cfg_target = '0;
        start = 1'b0; abort = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset match",     32'(match),     32'd0);
        checkOutput("reset done",      32'(done),      32'd0);
        checkOutput("reset timeout",   32'(timeout),   32'd0);
        checkOutput("reset busy",      32'(busy),      32'd0);
        checkOutput("reset cfg_ready", 32'(cfg_ready), 32'd1);
        checkOutput("reset match_cnt", 32'(match_cnt), 32'd0);
        rst = 1'b0;

        // Config A, target 3: the 18-beat stream hits at beats 9, 13 and 18.
        add_vec(1, PAT_A, MSK_A, 8'd3, 1, 0, 0, 0, 0, 0, 1, 0, 8'd0);
        for (int i = 0; i < 18; i++) begin
            b   = STREAM[17 - i];
            hit = (i + 1 == 9) || (i + 1 == 13) || (i + 1 == 18);
            cnt = (i + 1 >= 18) ? 8'd3 : (i + 1 >= 13) ? 8'd2 : (i + 1 >= 9) ? 8'd1 : 8'd0;
            add_vec(0, 9'h000, 9'h000, 8'd0, 0, 0, 1, b, hit, (i + 1 == 18), 1, 0, cnt);
        end
        add_vec(0, 9'h000, 9'h000, 8'd0, 0, 0, 0, 0, 0, 0, 0, 1, 8'd3);
        add_vec(0, 9'h000, 9'h000, 8'd0, 0, 1, 0, 0, 0, 0, 0, 1, 8'd3);

        // Fill guard: 8 beats that would match a zero-padded window, then a ninth.
        add_vec(0, 9'h000, 9'h000, 8'd0, 1, 0, 0, 0, 0, 0, 1, 0, 8'd0);
        for (int i = 0; i < 8; i++)
            add_vec(0, 9'h000, 9'h000, 8'd0, 0, 0, 1, GUARD[7 - i], 0, 0, 1, 0, 8'd0);
        add_vec(0, 9'h000, 9'h000, 8'd0, 0, 0, 1, 1, 0, 0, 1, 0, 8'd0);
        add_vec(0, 9'h000, 9'h000, 8'd0, 0, 1, 0, 0, 0, 0, 0, 1, 8'd0);

        // Config B with start in the same cycle; config offers and start while busy are ignored.
        add_vec(1, PAT_B, 9'h1FF, 8'd1, 1, 0, 0, 0, 0, 0, 1, 0, 8'd0);
        for (int i = 0; i < 9; i++)
            add_vec((i + 1 == 3) || (i + 1 == 4), 9'h000, 9'h1FF, 8'd0, (i + 1 == 5), 0, 1,
                    PAT_B[8 - i], (i == 8), (i == 8), 1, 0, (i == 8) ? 8'd1 : 8'd0);
        add_vec(0, 9'h000, 9'h000, 8'd0, 0, 0, 0, 0, 0, 0, 0, 1, 8'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].cv, vecs[i].pat, vecs[i].msk, vecs[i].tgt,
                          vecs[i].st, vecs[i].ab, vecs[i].bv, vecs[i].bi);
            checkOutput($sformatf("row%0d match", i),     32'(match),     32'(vecs[i].e_match));
            checkOutput($sformatf("row%0d done", i),      32'(done),      32'(vecs[i].e_done));
            checkOutput($sformatf("row%0d busy", i),      32'(busy),      32'(vecs[i].e_busy));
            checkOutput($sformatf("row%0d cfg_ready", i), 32'(cfg_ready), 32'(vecs[i].e_ready));
            checkOutput($sformatf("row%0d match_cnt", i), 32'(match_cnt), 32'(vecs[i].e_cnt));
            checkOutput($sformatf("row%0d timeout", i),   32'(timeout),   32'd0);
        end

        // Saturation: mask 0 makes every evaluated beat a hit; target 0 never ends the run.
        applyStimulus(1'b1, 9'h000, 9'h000, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        match_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            beat(1'b0);
            match_seen |= match;
        end
        checkOutput("sat fill no match", 32'(match_seen), 32'd0);
        done_seen = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            beat(1'b0);
            done_seen |= done;
            if (k == 1) begin
                checkOutput("sat first match", 32'(match), 32'd1);
                checkOutput("sat first cnt",   32'(match_cnt), 32'd1);
            end
            if (k == 255) checkOutput("sat cnt 255", 32'(match_cnt), 32'd255);
        end
        checkOutput("sat final cnt",   32'(match_cnt), 32'd255);
        checkOutput("sat final match", 32'(match),     32'd1);
        checkOutput("sat busy",        32'(busy),      32'd1);
        checkOutput("sat no done",     32'(done_seen), 32'd0);
        abort_cycle();
        checkOutput("sat abort busy",  32'(busy),      32'd0);

        // Abort on the cycle of the third hit.
        applyStimulus(1'b0, 9'h000, 9'h000, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (10) beat(1'b0);
        checkOutput("abort pre cnt", 32'(match_cnt), 32'd2);
        applyStimulus(1'b0, 9'h000, 9'h000, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("abort match", 32'(match),     32'd0);
        checkOutput("abort cnt",   32'(match_cnt), 32'd2);
        checkOutput("abort busy",  32'(busy),      32'd0);
        checkOutput("abort done",  32'(done),      32'd0);
        idle_cycle();
        checkOutput("abort after done", 32'(done),      32'd0);
        checkOutput("abort after cnt",  32'(match_cnt), 32'd2);

        // Reset in the middle of a run.
        applyStimulus(1'b0, 9'h000, 9'h000, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (10) beat(1'b0);
        rst = 1'b1;
        idle_cycle();
        rst = 1'b0;
        checkOutput("midrst busy",  32'(busy),      32'd0);
        checkOutput("midrst cnt",   32'(match_cnt), 32'd0);
        checkOutput("midrst match", 32'(match),     32'd0);
        checkOutput("midrst ready", 32'(cfg_ready), 32'd1);
        idle_cycle();
        checkOutput("midrst no done", 32'(done), 32'd0);

        // Timeout: hits only when the newest bit is 1.
        applyStimulus(1'b1, 9'h001, 9'h001, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        done_seen = 1'b0;
        repeat (9 + 63) begin
            beat(1'b0);
            done_seen |= done;
        end
        beat(1'b1);
        checkOutput("tmo late hit match", 32'(match),     32'd1);
        checkOutput("tmo late hit cnt",   32'(match_cnt), 32'd1);
        checkOutput("tmo late hit done",  32'(done),      32'd0);
        repeat (63) begin
            beat(1'b0);
            done_seen |= done;
        end
        checkOutput("tmo early done", 32'(done_seen), 32'd0);
        beat(1'b0);
`ifdef SEQ_MATCH_TIMEOUT_EN
        checkOutput("tmo done",    32'(done),    32'd1);
        checkOutput("tmo timeout", 32'(timeout), 32'd1);
        checkOutput("tmo busy",    32'(busy),    32'd1);
        idle_cycle();
        checkOutput("tmo idle busy",    32'(busy),    32'd0);
        checkOutput("tmo sticky",       32'(timeout), 32'd1);
`else
        checkOutput("tmo done",    32'(done),    32'd0);
        checkOutput("tmo timeout", 32'(timeout), 32'd0);
        checkOutput("tmo busy",    32'(busy),    32'd1);
        idle_cycle();
        checkOutput("tmo still busy", 32'(busy), 32'd1);
`endif
        abort_cycle();
        checkOutput("tmo abort busy", 32'(busy), 32'd0);
        applyStimulus(1'b0, 9'h000, 9'h000, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("tmo cleared by start", 32'(timeout),   32'd0);
        checkOutput("cnt cleared by start", 32'(match_cnt), 32'd0);
        abort_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
